// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter.
// Each granted access runs as a single WRITE or READ/RESP transaction that ends with a one-cycle ack.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, DONE} state_e;

  state_e                state_q;
  logic                  gnt_q;
  logic                  last_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ack0_q, ack1_q, busy_q, wen_q, ren_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic                  any_req;
  logic                  gnt_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // On contention the requester not granted last wins; otherwise the lone requester wins.
  always_comb begin
    any_req = req0 | req1;
    gnt_d   = (req0 && req1) ? ~last_q : req1;
    we_d    = gnt_d ? we1    : we0;
    addr_d  = gnt_d ? addr1  : addr0;
    wdata_d = gnt_d ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      wen_q  <= 1'b0;
      ren_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= gnt_d;
            last_q  <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= 1'b1;
            if (we_d) begin
              state_q <= WRITE;
              wen_q   <= 1'b1;
            end else begin
              state_q <= READ;
              ren_q   <= 1'b1;
            end
          end
        end
        WRITE: begin
          state_q <= DONE;
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
        end
        READ: state_q <= RESP;
        RESP: begin
          if (gnt_q) rdata1_q <= mem_dout;
          else       rdata0_q <= mem_dout;
          state_q <= DONE;
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  assign mem_wen   = wen_q;
  assign mem_ren   = ren_q;
  assign mem_waddr = addr_q;
  assign mem_raddr = addr_q;
  assign mem_din   = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule
